conv_layer_ctrl: RTL and testbench
==================================

# conv_layer_ctrl

Sequencing controller for one convolution layer. It drives the 3-bit `current_state` bus that the weight buffer, input line buffer and MAC array decode. It walks every output window of the feature map: preload the line buffer, load each window, stream KERNEL_SIZE² weights, apply the bias, and flag each finished result. It sits between the layer-level start/done handshake and the conv datapath.

## Interface
- KERNEL_SIZE, 3: kernel edge; SHIFT phase lasts KERNEL_SIZE*KERNEL_SIZE cycles.
- OUT_W, 4: output feature-map width (windows per row).
- OUT_H, 4: output feature-map height (rows).
- PRELOAD_CYCLES, 8: cycles the line buffer needs before the first window.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- i_start  in  1  single-cycle start request; honoured only in IDLE.
- i_abort  in  1  synchronous abort; wins over every other input.
- i_win_ready  in  1  input buffer holds a complete window.
- current_state  out  3  state bus to the datapath (encoding in package).
- o_win_x  out  $clog2(OUT_W)  column of the window in progress.
- o_win_y  out  $clog2(OUT_H)  row of the window in progress.
- o_acc_clear  out  1  MAC accumulator clear.
- o_result_valid  out  1  one-cycle pulse; MAC output is a finished pixel.
- o_busy  out  1  high in any state other than IDLE.
- o_done  out  1  one-cycle pulse after the last window's result.

## Operation
- States: IDLE=0, PRELOAD=1, LOAD=2, SHIFT=3, BIAS=4, DRAIN=5. Codes 6 and 7 are illegal and go to IDLE.
- IDLE: on i_start go to PRELOAD, clear the window counters to (0,0) and the cycle counter to 0.
- PRELOAD: stay PRELOAD_CYCLES cycles, then go to LOAD.
- LOAD: hold while i_win_ready=0, which stalls the layer; the weight ROM address stays at 0. When i_win_ready=1, go to SHIFT next cycle. o_acc_clear equals the LOAD-state decode.
- SHIFT: exactly KERNEL_SIZE² cycles with no stall, then go to BIAS.
- BIAS: exactly 1 cycle. Then:
  - If the window was not the last, go to LOAD. Advance o_win_x; on wrap from OUT_W-1 to 0, increment o_win_y.
  - If the window was (OUT_W-1, OUT_H-1), go to DRAIN.
- DRAIN: 2 cycles to flush the weight register and MAC, then go to IDLE with o_done.
- o_result_valid pulses exactly 2 cycles after each BIAS-state cycle. One cycle accounts for the registered weight, one for the MAC register. It is produced by a 2-stage shift register fed by the BIAS decode.
- i_abort: next state is IDLE. Clear the counters and the result_valid pipeline so no pulse reaches the output. o_done is not asserted.
- i_start while busy: ignored.
- i_start and i_abort in the same IDLE cycle: stay in IDLE.

## Timing
- Reset values:
  - current_state=IDLE(0); o_win_x=0; o_win_y=0.
  - o_acc_clear=0; o_result_valid=0; o_busy=0; o_done=0.
  - Cycle counter and valid pipeline cleared.
- All outputs are registered or a pure decode of the state register. There are no combinational paths from inputs to outputs.
- Window period with no stall: 1 (LOAD) + KERNEL_SIZE² + 1 (BIAS) cycles, which is 11 for the defaults.
- Total layer latency with no stall, from the i_start cycle to o_done: 1 + PRELOAD_CYCLES + OUT_W*OUT_H*(KERNEL_SIZE²+2) + 2 cycles.
- o_done is coincident with the last o_result_valid. It asserts in the final DRAIN cycle; current_state reads IDLE the next cycle.
- Counter widths come from $clog2. When the parameter is 1, the width is 1 and the counter holds at 0.

## Structure
- Shared package `conv_kernel_param` holds the STATE_* codes, the 3-bit state width and `DATA_WIDTH`. The weight buffer and line buffer decode the same constants.
- Sub-module `conv_win_counter`: a nested x/y counter with enable, clear, wrap and last flag. It is reused by the input line buffer.
- The FSM, cycle counter and valid pipeline live in the top module.

## Test plan
- Default parameters, i_win_ready tied to 1, pulse i_start:
  - PRELOAD lasts 8 cycles.
  - 16 o_result_valid pulses, 11 cycles apart.
  - o_done 187 cycles after i_start, then IDLE.
- Drop i_win_ready for 5 cycles at window (2,1): LOAD holds 5 extra cycles, the window counters stay frozen, and the result count is still 16.
- i_abort during SHIFT of window (1,0):
  - IDLE on the next cycle, counters at 0.
  - No o_result_valid after the abort; o_done never asserts.
- rst_n asserted mid-BIAS: all outputs go to their reset values immediately. After release, a new i_start runs a full, correct layer.
- Pulse i_start during SHIFT: no effect on state or counters.
- KERNEL_SIZE=1, OUT_W=1, OUT_H=1:
  - SHIFT lasts 1 cycle.
  - One result.
  - o_done at 1+8+3+2=14 cycles.

Source files
------------

// File: rtl/conv_layer_ctrl_pkg.sv
// conv_kernel_param: state codes and widths shared by the conv controller
// and the weight/line-buffer decoders.
package conv_kernel_param;
    localparam int STATE_W    = 3;
    localparam int DATA_WIDTH = 16;

    localparam logic [STATE_W-1:0] STATE_IDLE    = 3'd0;
    localparam logic [STATE_W-1:0] STATE_PRELOAD = 3'd1;
    localparam logic [STATE_W-1:0] STATE_LOAD    = 3'd2;
    localparam logic [STATE_W-1:0] STATE_SHIFT   = 3'd3;
    localparam logic [STATE_W-1:0] STATE_BIAS    = 3'd4;
    localparam logic [STATE_W-1:0] STATE_DRAIN   = 3'd5;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE    = STATE_IDLE,
        S_PRELOAD = STATE_PRELOAD,
        S_LOAD    = STATE_LOAD,
        S_SHIFT   = STATE_SHIFT,
        S_BIAS    = STATE_BIAS,
        S_DRAIN   = STATE_DRAIN
    } state_t;

    // Counter width that stays 1 bit when the range collapses to a single value.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/conv_win_counter.sv
// conv_win_counter: nested x/y window position counter with enable, clear,
// wrap and a last-window flag.
module conv_win_counter
    import conv_kernel_param::*;
#(
    parameter int W = 4,
    parameter int H = 4,
    localparam int XW = cnt_w(W),
    localparam int YW = cnt_w(H)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_clr,
    input  logic          i_en,
    output logic [XW-1:0] o_x,
    output logic [YW-1:0] o_y,
    output logic          o_last
);
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          x_wrap, y_wrap;

    always_comb begin
        x_wrap = x_q == XW'(W - 1);
        y_wrap = y_q == YW'(H - 1);
        x_d    = i_clr ? '0 : !i_en ? x_q : x_wrap ? '0 : x_q + 1'b1;
        y_d    = i_clr ? '0 : !(i_en && x_wrap) ? y_q : y_wrap ? '0 : y_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign o_x    = x_q;
    assign o_y    = y_q;
    assign o_last = x_wrap && y_wrap;
endmodule

// File: rtl/conv_layer_ctrl.sv
// conv_layer_ctrl: sequences one convolution layer (preload, per-window
// load/shift/bias, drain) and drives the datapath state bus.
module conv_layer_ctrl
    import conv_kernel_param::*;
#(
    parameter int KERNEL_SIZE    = 3,
    parameter int OUT_W          = 4,
    parameter int OUT_H          = 4,
    parameter int PRELOAD_CYCLES = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_start,
    input  logic                     i_abort,
    input  logic                     i_win_ready,
    output logic [STATE_W-1:0]       current_state,
    output logic [cnt_w(OUT_W)-1:0]  o_win_x,
    output logic [cnt_w(OUT_H)-1:0]  o_win_y,
    output logic                     o_acc_clear,
    output logic                     o_result_valid,
    output logic                     o_busy,
    output logic                     o_done
);
    localparam int SHIFT_CYCLES = KERNEL_SIZE * KERNEL_SIZE;
    localparam int DRAIN_CYCLES = 2;
    localparam int MAX_A        = (PRELOAD_CYCLES > SHIFT_CYCLES) ? PRELOAD_CYCLES : SHIFT_CYCLES;
    localparam int CNT_MAX      = (MAX_A > DRAIN_CYCLES) ? MAX_A : DRAIN_CYCLES;
    localparam int CW           = cnt_w(CNT_MAX);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    vld_q, vld_d;
    logic          done_q, done_d;
    logic          win_clr, win_en, win_last;

    // The cycle counter doubles as the weight ROM address; it sits at 0 in LOAD.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            S_IDLE:    state_d = i_start ? S_PRELOAD : S_IDLE;
            S_PRELOAD: if (cnt_q == CW'(PRELOAD_CYCLES - 1)) state_d = S_LOAD;
                       else cnt_d = cnt_q + 1'b1;
            S_LOAD:    state_d = i_win_ready ? S_SHIFT : S_LOAD;
            S_SHIFT:   if (cnt_q == CW'(SHIFT_CYCLES - 1)) state_d = S_BIAS;
                       else cnt_d = cnt_q + 1'b1;
            S_BIAS:    state_d = win_last ? S_DRAIN : S_LOAD;
            S_DRAIN:   if (cnt_q == CW'(DRAIN_CYCLES - 1)) state_d = S_IDLE;
                       else cnt_d = cnt_q + 1'b1;
            default:   state_d = S_IDLE;
        endcase
        if (i_abort) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end
        win_clr = i_abort || (state_q == S_IDLE && i_start);
        win_en  = !i_abort && state_q == S_BIAS && !win_last;
        vld_d   = i_abort ? 2'b00 : {vld_q[0], state_q == S_BIAS};
        done_d  = !i_abort && state_q == S_DRAIN && cnt_q == '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            vld_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vld_q   <= vld_d;
            done_q  <= done_d;
        end
    end

    conv_win_counter #(
        .W (OUT_W),
        .H (OUT_H)
    ) u_win (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (win_clr),
        .i_en   (win_en),
        .o_x    (o_win_x),
        .o_y    (o_win_y),
        .o_last (win_last)
    );

    assign current_state  = state_q;
    assign o_acc_clear    = state_q == S_LOAD;
    assign o_busy         = state_q != S_IDLE;
    assign o_result_valid = vld_q[1];
    assign o_done         = done_q;
endmodule

// File: tb/tb_conv_layer_ctrl.sv
// tb_conv_layer_ctrl: checks the controller cycle-by-cycle against a schedule
// built from the layer timing rules (phase lengths, stalls, abort, reset).
module tb_conv_layer_ctrl;
    import conv_kernel_param::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       b_start = 1'b0, b_abort = 1'b0, b_ready = 1'b1;
    logic [2:0] b_state;
    logic [1:0] b_x, b_y;
    logic       b_clr, b_vld, b_busy, b_done;

    logic       s_start = 1'b0, s_abort = 1'b0, s_ready = 1'b1;
    logic [2:0] s_state;
    logic       s_x, s_y;
    logic       s_clr, s_vld, s_busy, s_done;

    conv_layer_ctrl #(
        .KERNEL_SIZE(3), .OUT_W(4), .OUT_H(4), .PRELOAD_CYCLES(8)
    ) u_big (
        .clk(clk), .rst_n(rst_n), .i_start(b_start), .i_abort(b_abort),
        .i_win_ready(b_ready), .current_state(b_state), .o_win_x(b_x),
        .o_win_y(b_y), .o_acc_clear(b_clr), .o_result_valid(b_vld),
        .o_busy(b_busy), .o_done(b_done)
    );

    conv_layer_ctrl #(
        .KERNEL_SIZE(1), .OUT_W(1), .OUT_H(1), .PRELOAD_CYCLES(8)
    ) u_small (
        .clk(clk), .rst_n(rst_n), .i_start(s_start), .i_abort(s_abort),
        .i_win_ready(s_ready), .current_state(s_state), .o_win_x(s_x),
        .o_win_y(s_y), .o_acc_clear(s_clr), .o_result_valid(s_vld),
        .o_busy(s_busy), .o_done(s_done)
    );

    // One entry per cycle; x/y of -1 means the position is not checked.
    typedef struct {
        int st;
        int x;
        int y;
        bit vld;
        bit done;
        bit rdy;
    } exp_t;

    exp_t tr[$];
    exp_t rst_e = '{0, 0, 0, 1'b0, 1'b0, 1'b1};
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        if (exp >= 0) begin
            checks++;
            assert (obs === exp) else begin
                errors++;
                $error("FAIL %s at %0t: observed %0d expected %0d", tag, $time, obs, exp);
            end
        end
    endtask

    task automatic check(input bit sel, input exp_t e);
        chk("state",        sel ? int'(s_state) : int'(b_state), e.st);
        chk("win_x",        sel ? int'(s_x)     : int'(b_x),     e.x);
        chk("win_y",        sel ? int'(s_y)     : int'(b_y),     e.y);
        chk("acc_clear",    sel ? int'(s_clr)   : int'(b_clr),   int'(e.st == 2));
        chk("busy",         sel ? int'(s_busy)  : int'(b_busy),  int'(e.st != 0));
        chk("result_valid", sel ? int'(s_vld)   : int'(b_vld),   int'(e.vld));
        chk("done",         sel ? int'(s_done)  : int'(b_done),  int'(e.done));
    endtask

    task automatic drive(input bit sel, input bit st, input bit ab, input bit rdy);
        if (sel) {s_start, s_abort, s_ready} = {st, ab, rdy};
        else     {b_start, b_abort, b_ready} = {st, ab, rdy};
    endtask

    task automatic add(input int st, input int x, input int y, input bit rdy);
        tr.push_back('{st, x, y, 1'b0, 1'b0, rdy});
    endtask

    function automatic bit rb(input bit rnd);
        return rnd ? ($urandom_range(0, 1) != 0) : 1'b1;
    endfunction

    // Expected schedule of a full layer starting with the i_start cycle.
    task automatic build(input int k, input int w, input int h, input int stall_win,
                         input int stall_len, input bit rnd);
        int s;
        tr.delete();
        add(0, -1, -1, 1'b1);
        for (int i = 0; i < 8; i++) add(1, 0, 0, rb(rnd));
        for (int n = 0; n < w * h; n++) begin
            s = (n == stall_win) ? stall_len : rnd ? int'($urandom_range(0, 2)) : 0;
            for (int i = 0; i < s; i++) add(2, n % w, n / w, 1'b0);
            add(2, n % w, n / w, 1'b1);
            for (int i = 0; i < k * k; i++) add(3, n % w, n / w, rb(rnd));
            add(4, n % w, n / w, rb(rnd));
        end
        add(5, w - 1, h - 1, rb(rnd));
        add(5, w - 1, h - 1, rb(rnd));
        tr[tr.size() - 1].done = 1'b1;
        for (int i = 0; i + 2 < tr.size(); i++)
            if (tr[i].st == 4) tr[i + 2].vld = 1'b1;
        repeat (3) add(0, -1, -1, 1'b1);
    endtask

    task automatic run(input bit sel, input int abort_at, input int rst_at, input bit noise);
        bit st;
        bit ab;
        for (int i = 0; i < tr.size(); i++) begin
            @(negedge clk);
            check(sel, tr[i]);
            if (i == rst_at) begin
                drive(sel, 1'b0, 1'b0, 1'b1);
                rst_n = 1'b0;
                #1;
                check(sel, rst_e);
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            st = (i == 0) || (noise && tr[i].st == 3 && $urandom_range(0, 3) == 0);
            ab = (i == abort_at);
            drive(sel, st, ab, tr[i].rdy);
            if (ab) begin
                while (tr.size() > i + 1) void'(tr.pop_back());
                repeat (3) add(0, 0, 0, 1'b1);
            end
        end
        drive(sel, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check(1'b0, rst_e);
        check(1'b1, rst_e);
        rst_n = 1'b1;

        // Nominal layer with i_win_ready high and stray i_start pulses in SHIFT.
        build(3, 4, 4, -1, 0, 1'b0);
        run(1'b0, -1, -1, 1'b1);

        // Five-cycle stall at window (2,1).
        build(3, 4, 4, 6, 5, 1'b0);
        run(1'b0, -1, -1, 1'b0);

        // Random stalls and random i_win_ready outside LOAD.
        build(3, 4, 4, -1, 0, 1'b1);
        run(1'b0, -1, -1, 1'b1);

        // Abort somewhere in SHIFT of window (1,0).
        build(3, 4, 4, -1, 0, 1'b0);
        run(1'b0, 21 + int'($urandom_range(0, 8)), -1, 1'b0);

        // Asynchronous reset in the BIAS cycle of window (3,0), then a full layer.
        build(3, 4, 4, -1, 0, 1'b0);
        run(1'b0, -1, 52, 1'b0);
        build(3, 4, 4, -1, 0, 1'b1);
        run(1'b0, -1, -1, 1'b0);

        // i_start together with i_abort in IDLE.
        build(3, 4, 4, -1, 0, 1'b0);
        run(1'b0, 0, -1, 1'b0);

        // Degenerate 1x1 kernel on a 1x1 map.
        build(1, 1, 1, -1, 0, 1'b0);
        run(1'b1, -1, -1, 1'b0);
        build(1, 1, 1, -1, 0, 1'b1);
        run(1'b1, -1, -1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
